// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: FIFO-buffered sample feeder that strobes the codec on each word-sent rising edge.
// Define UNDERRUN_HOLD_EN to repeat the last popped sample on underrun instead of sending silence.
module audio_sample_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int START_LEVEL = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  word_sent,
  output logic [DATA_WIDTH-1:0] codec_data,
  output logic                  send_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  primed,
  output logic [15:0]           underrun_count
);
  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] under_sample;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic word_sent_q, req_q, srv_q;
  logic push, pop, starve;
  assign in_ready = level < (ADDR_WIDTH+1)'(DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = req_q && state == RUN && level != '0;
  assign starve   = req_q && state == RUN && level == '0;
`ifdef UNDERRUN_HOLD_EN
  // codec_data only ever holds popped samples (or its reset zero), so it is the hold value
  assign under_sample = codec_data;
`else
  assign under_sample = '0;
`endif
  always_ff @(posedge clock)
    state <= reset ? FILL : state_n;
  always_comb
    state_n = (state == FILL && level >= (ADDR_WIDTH+1)'(START_LEVEL)) ? RUN : starve ? FILL : state;
  always_comb
    primed = state == RUN;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= in_data;
  // request sampled -> served (data/pop) -> strobe: one stage per edge
  always_ff @(posedge clock) begin
    if (reset) begin
      word_sent_q    <= 1'b0;
      req_q          <= 1'b0;
      srv_q          <= 1'b0;
      send_data      <= 1'b0;
      codec_data     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      underrun_count <= '0;
    end else begin
      word_sent_q <= word_sent;
      req_q       <= word_sent && !word_sent_q;
      srv_q       <= req_q;
      send_data   <= srv_q;
      if (req_q) codec_data <= pop ? mem[rd_ptr] : under_sample;
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      level <= level + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      if (starve && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
    end
  end
endmodule
